mmio_peripheral: RTL and testbench

Memory-mapped I/O stage directly downstream of the single-cycle CPU's data-memory port. It decodes the CPU's `Address`, `Write_data`, `MemRead` and `MemWrite` signals against a fixed 32-byte window, and it owns:
- the LED output register,
- a synchronised and debounced switch input,
- a reloadable 32-bit timer with interrupt,
- a free-running cycle counter.

The CPU's read mux selects `Read_data` from this block whenever `hit` is high.

---
 rtl/mmio_peripheral.sv | 94 +++++++++
 tb/tb_mmio_peripheral.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_peripheral.sv
// mmio_peripheral: memory-mapped LED, debounced switches, reloadable timer and cycle counter
// Ports: clk/reset (sync, active-low); Address/Write_data/MemRead/MemWrite CPU data port;
// Read_data combinational load data; hit window decode; SW raw switches; LEDR LED register; irq timer interrupt.
module mmio_peripheral #(
   parameter logic [31:0] BASE_ADDR       = 32'h40000000,
   parameter logic [19:0] DEBOUNCE_CYCLES = 20'd50000,
   parameter int          IO_WIDTH        = 10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         Address,
   input  logic [31:0]         Write_data,
   input  logic                MemRead,
   input  logic                MemWrite,
   output logic [31:0]         Read_data,
   output logic                hit,
   input  logic [IO_WIDTH-1:0] SW,
   output logic [IO_WIDTH-1:0] LEDR,
   output logic                irq
);
   localparam logic [19:0] DB_LAST = DEBOUNCE_CYCLES - 20'd1;
   logic [2:0]          off;
   logic                wr, ovf, tcon_wr;
   logic [IO_WIDTH-1:0] led_q, led_d, sync1_q, sync2_q, cand_q, sw_q, sw_d;
   logic [19:0]         cnt_q, cnt_d;
   logic [31:0]         th_q, th_d, tl_q, tl_d, tick_q, rsel;
   logic                en_q, en_d, ie_q, ie_d, st_q, st_d, irq_q;
   logic                unused_ok;
   assign unused_ok = ^Address[1:0];
   assign hit       = Address[31:5] == BASE_ADDR[31:5];
   assign off       = Address[4:2];
   assign wr        = MemWrite & hit;
   assign tcon_wr   = wr && off == 3'd4;
   assign ovf       = en_q & (&tl_q);
   assign LEDR      = led_q;
   assign irq       = irq_q;
   always_comb begin
      led_d = (wr && off == 3'd0) ? Write_data[IO_WIDTH-1:0] : led_q;
      th_d  = (wr && off == 3'd2) ? Write_data : th_q;
      // a CPU store to TL beats both the reload and the increment
      tl_d  = (wr && off == 3'd3) ? Write_data : ovf ? th_q : en_q ? tl_q + 32'd1 : tl_q;
      en_d  = tcon_wr ? Write_data[0] : en_q;
      ie_d  = tcon_wr ? Write_data[1] : ie_q;
      // overflow set dominates a simultaneous write-1-to-clear
      st_d  = ovf | (st_q & ~(tcon_wr & Write_data[2]));
      // counter restarts on any change of the candidate and saturates once accepted
      cnt_d = (sync2_q != cand_q) ? 20'd0 : (cnt_q == DB_LAST) ? cnt_q : cnt_q + 20'd1;
      sw_d  = (sync2_q == cand_q && cnt_q == DB_LAST) ? cand_q : sw_q;
   end
   always_comb begin
      rsel = 32'h0;
      case (off)
         3'd0:    rsel = 32'(led_q);
         3'd1:    rsel = 32'(sw_q);
         3'd2:    rsel = th_q;
         3'd3:    rsel = tl_q;
         3'd4:    rsel = {29'h0, st_q, ie_q, en_q};
         3'd5:    rsel = tick_q;
         default: rsel = 32'h0;
      endcase
   end
   assign Read_data = (MemRead && hit) ? rsel : 32'h0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         led_q   <= '0;
         sync1_q <= '0;
         sync2_q <= '0;
         cand_q  <= '0;
         cnt_q   <= '0;
         sw_q    <= '0;
         th_q    <= '0;
         tl_q    <= '0;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         st_q    <= 1'b0;
         tick_q  <= '0;
         irq_q   <= 1'b0;
      end else begin
         led_q   <= led_d;
         sync1_q <= SW;
         sync2_q <= sync1_q;
         cand_q  <= sync2_q;
         cnt_q   <= cnt_d;
         sw_q    <= sw_d;
         th_q    <= th_d;
         tl_q    <= tl_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         st_q    <= st_d;
         tick_q  <= tick_q + 32'd1;
         irq_q   <= st_q & ie_q;
      end
   end
endmodule

// File: tb/tb_mmio_peripheral.sv
// tb_mmio_peripheral: randomized and directed checks of mmio_peripheral against a register-level model
module tb_mmio_peripheral;
   localparam logic [31:0] BASE = 32'h40000000;
   logic        clk, reset, MemRead, MemWrite, hit, irq;
   logic [31:0] Address, Write_data, Read_data;
   logic [9:0]  SW, LEDR;
   int          n_tests = 0, n_fail = 0;
   logic [31:0] rd_obs;
   logic        hit_obs;
   logic        sw_known = 1'b1;
   logic [9:0]  m_led = '0, m_swreg = '0;
   logic [31:0] m_th = '0, m_tl = '0, m_tick = '0;
   logic        m_en = 1'b0, m_ie = 1'b0, m_st = 1'b0, m_irq = 1'b0;

   mmio_peripheral #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(20'd4), .IO_WIDTH(10)) dut (
      .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
      .MemRead(MemRead), .MemWrite(MemWrite), .Read_data(Read_data), .hit(hit),
      .SW(SW), .LEDR(LEDR), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic m_hit(input logic [31:0] a);
      return (a >> 5) == (BASE >> 5);
   endfunction

   function automatic int m_off(input logic [31:0] a);
      return int'((a & 32'h1F) / 4);
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a);
      case (m_off(a))
         0:       return {22'h0, m_led};
         1:       return {22'h0, m_swreg};
         2:       return m_th;
         3:       return m_tl;
         4:       return {29'h0, m_st, m_ie, m_en};
         5:       return m_tick;
         default: return 32'h0;
      endcase
   endfunction

   // register-level effect of one clock edge
   task automatic model_edge(input logic w, input int o, input logic [31:0] d);
      logic [31:0] tl_n;
      logic        st_n, overflow;
      if (!reset) begin
         m_led = '0; m_swreg = '0; m_th = '0; m_tl = '0; m_tick = '0;
         m_en = 1'b0; m_ie = 1'b0; m_st = 1'b0; m_irq = 1'b0;
         return;
      end
      overflow = m_en && m_tl == 32'hFFFFFFFF;
      tl_n = !m_en ? m_tl : overflow ? m_th : m_tl + 1;
      st_n = m_st;
      if (w && o == 3) tl_n = d;
      if (w && o == 4 && d[2]) st_n = 1'b0;
      if (overflow) st_n = 1'b1;
      m_irq  = m_st && m_ie;
      m_tick = m_tick + 1;
      m_tl   = tl_n;
      m_st   = st_n;
      if (w && o == 0) m_led = d[9:0];
      if (w && o == 2) m_th = d;
      if (w && o == 4) begin m_en = d[0]; m_ie = d[1]; end
   endtask

   task automatic step(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] exp_rd;
      Address = a; Write_data = d; MemWrite = w; MemRead = r;
      #4;
      exp_rd = (r && m_hit(a)) ? m_read(a) : 32'h0;
      check("hit", {31'h0, hit}, {31'h0, m_hit(a)});
      if (sw_known || !(r && m_hit(a) && m_off(a) == 1)) check("rdata", Read_data, exp_rd);
      rd_obs = Read_data;
      hit_obs = hit;
      @(posedge clk);
      model_edge(w && m_hit(a), m_off(a), d);
      #1;
      check("ledr", {22'h0, LEDR}, {22'h0, m_led});
      check("irq", {31'h0, irq}, {31'h0, m_irq});
      MemWrite = 1'b0; MemRead = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      step(1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [31:0] a);
      step(1'b0, 1'b1, a, 32'h0);
   endtask

   initial begin
      int lat;
      logic [31:0] t1, a, d;
      logic [2:0] o;
      reset = 1'b0; SW = '0; Address = '0; Write_data = '0; MemRead = 1'b0; MemWrite = 1'b0;
      @(posedge clk); #1;
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("rst_ledr", {22'h0, LEDR}, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      reset = 1'b1;
      // LED store and load
      wr(BASE, 32'h3A5);
      check("led_store", {22'h0, LEDR}, 32'h3A5);
      rd(BASE);
      check("led_load", rd_obs, 32'h3A5);
      // switch debounce: short glitch rejected, stable value accepted
      sw_known = 1'b0;
      SW = 10'h008;
      repeat (3) rd(BASE + 4);
      SW = 10'h000;
      for (int i = 0; i < 10; i++) begin
         rd(BASE + 4);
         check("sw_glitch", rd_obs, 32'h0);
      end
      SW = 10'h008;
      lat = -1;
      for (int k = 1; k <= 10; k++) begin
         rd(BASE + 4);
         if (lat < 0 && rd_obs == 32'h8) lat = k - 1;
      end
      check("sw_latency", {31'h0, lat >= 5 && lat <= 7}, 32'h1);
      m_swreg = 10'h008;
      sw_known = 1'b1;
      rd(BASE + 4);
      check("sw_value", rd_obs, 32'h8);
      // timer overflow, reload and interrupt
      wr(BASE + 8, 32'hFFFFFFF0);
      wr(BASE + 12, 32'hFFFFFFFE);
      wr(BASE + 16, 32'h3);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      check("irq_pre", {31'h0, irq}, 32'h0);
      rd(BASE + 12);
      check("tl_reload", rd_obs, 32'hFFFFFFF0);
      check("irq_rise", {31'h0, irq}, 32'h1);
      rd(BASE + 16);
      check("tcon_st", rd_obs, 32'h7);
      wr(BASE + 16, 32'h7);
      rd(BASE + 16);
      check("tcon_clr", rd_obs, 32'h3);
      check("irq_fall", {31'h0, irq}, 32'h0);
      wr(BASE + 16, 32'h4);
      // TL write on the overflow edge
      wr(BASE + 8, 32'h100);
      wr(BASE + 12, 32'hFFFFFFFE);
      wr(BASE + 16, 32'h1);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      wr(BASE + 12, 32'h5);
      rd(BASE + 12);
      check("tl_wr_wins", rd_obs, 32'h5);
      rd(BASE + 16);
      check("st_on_tlwr", rd_obs, 32'h5);
      // W1C on the overflow edge
      wr(BASE + 16, 32'h5);
      wr(BASE + 12, 32'hFFFFFFFE);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      wr(BASE + 16, 32'h5);
      rd(BASE + 16);
      check("st_set_wins", rd_obs, 32'h5);
      wr(BASE + 16, 32'h4);
      // decode boundaries
      step(1'b1, 1'b1, BASE + 32'h20, 32'h155);
      check("oob_hit", {31'h0, hit_obs}, 32'h0);
      check("oob_rdata", rd_obs, 32'h0);
      rd(BASE);
      check("oob_nowrite", rd_obs, 32'h3A5);
      rd(BASE + 32'h18);
      check("off18", rd_obs, 32'h0);
      rd(BASE + 3);
      check("low_bits", rd_obs, 32'h3A5);
      rd(BASE + 32'h14);
      t1 = rd_obs;
      wr(BASE + 32'h14, 32'h0);
      rd(BASE + 32'h14);
      check("tick_ro", rd_obs, t1 + 32'd2);
      // randomized register traffic
      for (int i = 0; i < 400; i++) begin
         o = 3'($urandom_range(0, 7));
         a = BASE | {27'h0, o, 2'($urandom_range(0, 3))};
         if ($urandom_range(0, 9) == 0) a = BASE + 32'h20 * $urandom_range(1, 4) + {27'h0, o, 2'b00};
         d = $urandom;
         if (o == 3'd3 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFF0 | 32'($urandom_range(0, 15));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
      end
      // reset in the middle of a count and a debounce
      wr(BASE + 16, 32'h3);
      wr(BASE + 12, 32'h1234);
      SW = 10'h000;
      sw_known = 1'b0;
      step(1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b0;
      step(1'b0, 1'b0, 32'h0, 32'h0);
      reset = 1'b1;
      sw_known = 1'b1;
      check("mid_rst_irq", {31'h0, irq}, 32'h0);
      rd(BASE + 32'h14);
      check("mid_rst_tick", rd_obs, 32'h0);
      rd(BASE + 12);
      check("mid_rst_tl", rd_obs, 32'h0);
      rd(BASE + 4);
      check("mid_rst_sw", rd_obs, 32'h0);
      rd(BASE + 16);
      check("mid_rst_tcon", rd_obs, 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
